// File: rtl/ibex_bloom_unit.sv
// ibex_bloom_unit: multi-filter Bloom-filter accelerator for the EX stage.
// Ports:
//   clk_i, rst_ni        clock, synchronous active-low reset
//   bloom_en_i           start request, sampled only when idle
//   bloom_op_i           00 INSERT, 01 CHECK, 10 CLEAR, 11 COUNT
//   operand_a_i          key
//   operand_b_i          filter select in the low FselW bits
//   data_ind_timing_i    disables CHECK early exit
//   kill_i               abort from ID/controller
//   ready_i              ID consumes the result
//   busy_o               unit not idle
//   valid_o              result valid
//   result_o             op result
module ibex_bloom_unit #(
    parameter int unsigned FilterBits = 1024,
    parameter int unsigned NumHashes  = 3,
    parameter int unsigned NumFilters = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        bloom_en_i,
    input  logic [1:0]  bloom_op_i,
    input  logic [31:0] operand_a_i,
    input  logic [31:0] operand_b_i,
    input  logic        data_ind_timing_i,
    input  logic        kill_i,
    input  logic        ready_i,
    output logic        busy_o,
    output logic        valid_o,
    output logic [31:0] result_o
);
    localparam int unsigned IdxW  = $clog2(FilterBits);
    localparam int unsigned Words = FilterBits / 32;
    localparam int unsigned WordW = IdxW - 5;
    localparam int unsigned FselW = NumFilters > 1 ? $clog2(NumFilters) : 1;
    localparam int unsigned Depth = NumFilters * Words;
    localparam int unsigned AddrW = FselW + WordW;

    localparam logic [1:0] OpInsert = 2'b00;
    localparam logic [1:0] OpCheck  = 2'b01;
    localparam logic [1:0] OpClear  = 2'b10;
    localparam logic [1:0] OpCount  = 2'b11;

    typedef enum logic [1:0] {IDLE, HASH, SWEEP, DONE} state_e;

    state_e             state, state_next;
    logic [31:0]        key;
    logic [1:0]         op;
    logic [FselW-1:0]   fsel;
    logic               bad;
    logic [2:0]         j;
    logic [WordW-1:0]   w;
    logic [16:0]        acc;
    logic               present;
    logic [31:0]        mem [Depth];

    logic [FselW-1:0]   fsel_in;
    logic               bad_in;
    logic [IdxW-1:0]    idx;
    logic [AddrW-1:0]   addr;
    logic [31:0]        word;
    logic               hit;
    logic               last_hash;
    logic               last_word;
    logic               early_exit;
    logic               unused_b;

    function automatic logic [IdxW-1:0] hash_idx(input logic [31:0] k, input logic [2:0] i);
        logic [31:0] seed;
        logic [31:0] mix;
        logic [15:0] fold;
        logic [4:0]  r;
        seed = 32'h9E3779B9 * ({29'b0, i} + 32'd1);
        // 5-bit arithmetic makes the rotate amount wrap mod 32; a zero amount
        // shifts right by 32, which yields zero and leaves k unrotated.
        r    = 5'({2'b0, i} * 5'd5 + 5'd7);
        mix  = k ^ ((k << r) | (k >> (6'd32 - {1'b0, r}))) ^ seed;
        fold = mix[31:16] ^ mix[15:0];
        return fold[IdxW-1:0];
    endfunction

    assign fsel_in  = operand_b_i[FselW-1:0];
    assign bad_in   = 32'(fsel_in) >= NumFilters;
    assign unused_b = ^operand_b_i[31:FselW];

    always_comb begin
        idx        = hash_idx(key, j);
        addr       = {fsel, state == SWEEP ? w : idx[IdxW-1:5]};
        word       = mem[addr];
        hit        = word[idx[4:0]];
        last_hash  = j == 3'(NumHashes - 1);
        last_word  = w == WordW'(Words - 1);
        early_exit = op == OpCheck && !hit && !data_ind_timing_i;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:  if (bloom_en_i) state_next = bad_in ? DONE : (bloom_op_i[1] ? SWEEP : HASH);
            HASH:  state_next = kill_i ? IDLE : ((last_hash || early_exit) ? DONE : HASH);
            SWEEP: state_next = kill_i ? IDLE : (last_word ? DONE : SWEEP);
            DONE:  state_next = (kill_i || ready_i) ? IDLE : DONE;
        endcase
    end

    // Writes in the kill cycle still land: a partial INSERT or CLEAR only
    // leaves extra set or cleared bits, which Bloom semantics tolerate.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state   <= IDLE;
            key     <= '0;
            op      <= '0;
            fsel    <= '0;
            bad     <= 1'b0;
            j       <= '0;
            w       <= '0;
            acc     <= '0;
            present <= 1'b0;
            for (int k = 0; k < Depth; k++) mem[k] <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && bloom_en_i) begin
                key     <= operand_a_i;
                op      <= bloom_op_i;
                fsel    <= fsel_in;
                bad     <= bad_in;
                j       <= '0;
                w       <= '0;
                acc     <= '0;
                present <= 1'b1;
            end
            if (state == HASH) begin
                present <= present & hit;
                j       <= j + 3'd1;
                if (op == OpInsert) mem[addr][idx[4:0]] <= 1'b1;
            end
            if (state == SWEEP) begin
                w <= w + WordW'(1);
                if (op == OpClear) mem[addr] <= '0;
                else acc <= acc + 17'($countones(word));
            end
        end
    end

    assign busy_o   = state != IDLE;
    assign valid_o  = state == DONE;
    assign result_o = !valid_o ? 32'h0 :
                      bad ? 32'hFFFF_FFFF :
                      op == OpCount ? {15'b0, acc} :
                      op == OpClear ? 32'h0 : {31'b0, present};
endmodule

// File: tb/tb_ibex_bloom_unit.sv
// tb_ibex_bloom_unit: directed vector and sequence bench for ibex_bloom_unit.
// Ports: none; drives clk_i, rst_ni and all request inputs of the DUT.
module tb_ibex_bloom_unit;
    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        bloom_en_i = 1'b0;
    logic [1:0]  bloom_op_i = 2'b00;
    logic [31:0] operand_a_i = '0;
    logic [31:0] operand_b_i = '0;
    logic        data_ind_timing_i = 1'b0;
    logic        kill_i = 1'b0;
    logic        ready_i = 1'b0;
    logic        busy_o;
    logic        valid_o;
    logic [31:0] result_o;

    localparam logic [1:0] INS = 2'b00, CHK = 2'b01, CLR = 2'b10, CNT = 2'b11;

    ibex_bloom_unit dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .bloom_en_i(bloom_en_i), .bloom_op_i(bloom_op_i),
        .operand_a_i(operand_a_i), .operand_b_i(operand_b_i),
        .data_ind_timing_i(data_ind_timing_i), .kill_i(kill_i), .ready_i(ready_i),
        .busy_o(busy_o), .valid_o(valid_o), .result_o(result_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        dit;
        logic [31:0] res;
        int          lat;
    } vec_t;

    vec_t vecs[16];
    int n_checks = 0;
    int n_fail = 0;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic start(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic dit);
        bloom_en_i = 1'b1;
        bloom_op_i = op;
        operand_a_i = a;
        operand_b_i = b;
        data_ind_timing_i = dit;
        tick();
        bloom_en_i = 1'b0;
    endtask

    task automatic wait_valid(input string name, output int lat);
        lat = 1;
        while (!valid_o && lat < 200) begin
            tick();
            lat++;
        end
        if (!valid_o) check({name, " timeout"}, {31'b0, valid_o}, 32'd1);
    endtask

    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic dit, output logic [31:0] res, output int lat);
        start(op, a, b, dit);
        wait_valid(name, lat);
        res = result_o;
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
    endtask

    initial begin
        logic [31:0] res;
        int lat;
        // Key 0 hashes to 0x38E, 0x31C, 0x38D; key 0x12345678 to 0x1E0, 0x314, 0x359.
        vecs[0]  = '{CNT, 32'h0, 32'h0, 1'b0, 32'd0, 33};
        vecs[1]  = '{INS, 32'h0, 32'h0, 1'b0, 32'd0, 4};
        vecs[2]  = '{CNT, 32'h0, 32'h0, 1'b0, 32'd3, 33};
        vecs[3]  = '{CNT, 32'h0, 32'h1, 1'b0, 32'd0, 33};
        vecs[4]  = '{CHK, 32'h0, 32'h0, 1'b0, 32'd1, 4};
        vecs[5]  = '{CHK, 32'h12345678, 32'h0, 1'b0, 32'd0, 2};
        vecs[6]  = '{CHK, 32'h12345678, 32'h0, 1'b1, 32'd0, 4};
        vecs[7]  = '{INS, 32'h0, 32'h0, 1'b0, 32'd1, 4};
        vecs[8]  = '{CNT, 32'h0, 32'h0, 1'b0, 32'd3, 33};
        vecs[9]  = '{INS, 32'h12345678, 32'h1, 1'b0, 32'd0, 4};
        vecs[10] = '{CNT, 32'h0, 32'h1, 1'b0, 32'd3, 33};
        vecs[11] = '{CHK, 32'h12345678, 32'h1, 1'b0, 32'd1, 4};
        vecs[12] = '{CHK, 32'h0, 32'h1, 1'b0, 32'd0, 2};
        vecs[13] = '{CLR, 32'h0, 32'h1, 1'b0, 32'd0, 33};
        vecs[14] = '{CNT, 32'h0, 32'h1, 1'b0, 32'd0, 33};
        vecs[15] = '{CNT, 32'h0, 32'hFFFF_FFFE, 1'b0, 32'd3, 33};

        repeat (3) tick();
        check("reset busy", {31'b0, busy_o}, 32'd0);
        check("reset valid", {31'b0, valid_o}, 32'd0);
        check("reset result", result_o, 32'd0);
        rst_ni = 1'b1;
        tick();

        for (int i = 0; i < 16; i++) begin
            run_op($sformatf("v%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].dit, res, lat);
            check($sformatf("v%0d result", i), res, vecs[i].res);
            check($sformatf("v%0d latency", i), 32'(lat), 32'(vecs[i].lat));
        end

        // Hold the result for five cycles; an en pulse meanwhile is ignored.
        start(CHK, 32'h0, 32'h0, 1'b0);
        wait_valid("hold", lat);
        for (int k = 0; k < 5; k++) begin
            if (k == 1) begin
                bloom_en_i = 1'b1;
                bloom_op_i = CNT;
            end
            tick();
            bloom_en_i = 1'b0;
            check($sformatf("hold%0d valid", k), {31'b0, valid_o}, 32'd1);
            check($sformatf("hold%0d busy", k), {31'b0, busy_o}, 32'd1);
            check($sformatf("hold%0d result", k), result_o, 32'd1);
        end
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        check("hold release valid", {31'b0, valid_o}, 32'd0);
        check("hold release busy", {31'b0, busy_o}, 32'd0);
        tick();
        check("hold no second op", {31'b0, busy_o}, 32'd0);

        // Kill during the second SWEEP cycle of CLEAR: only words 0 and 1 cleared.
        start(CLR, 32'h0, 32'h0, 1'b0);
        tick();
        kill_i = 1'b1;
        tick();
        kill_i = 1'b0;
        check("kill clear valid", {31'b0, valid_o}, 32'd0);
        check("kill clear busy", {31'b0, busy_o}, 32'd0);
        run_op("kcnt", CNT, 32'h0, 32'h0, 1'b0, res, lat);
        check("kill clear count", res, 32'd3);

        // Kill together with ready in DONE: result dropped, back to idle.
        start(CHK, 32'h0, 32'h0, 1'b0);
        wait_valid("kdone", lat);
        kill_i = 1'b1;
        ready_i = 1'b1;
        tick();
        kill_i = 1'b0;
        ready_i = 1'b0;
        check("kill done valid", {31'b0, valid_o}, 32'd0);
        check("kill done busy", {31'b0, busy_o}, 32'd0);

        // Kill after the first INSERT hash: only bit 0x1E0 lands in filter 0.
        start(INS, 32'h12345678, 32'h0, 1'b0);
        kill_i = 1'b1;
        tick();
        kill_i = 1'b0;
        check("kill hash busy", {31'b0, busy_o}, 32'd0);
        check("kill hash valid", {31'b0, valid_o}, 32'd0);
        run_op("khcnt", CNT, 32'h0, 32'h0, 1'b0, res, lat);
        check("kill hash count", res, 32'd4);
        run_op("khchk", CHK, 32'h12345678, 32'h0, 1'b1, res, lat);
        check("kill hash check", res, 32'd0);

        // Reset in the middle of an INSERT.
        start(INS, 32'h0, 32'h1, 1'b0);
        tick();
        rst_ni = 1'b0;
        tick();
        check("midrst busy", {31'b0, busy_o}, 32'd0);
        check("midrst valid", {31'b0, valid_o}, 32'd0);
        check("midrst result", result_o, 32'd0);
        rst_ni = 1'b1;
        tick();
        run_op("rcnt0", CNT, 32'h0, 32'h0, 1'b0, res, lat);
        check("midrst count f0", res, 32'd0);
        run_op("rcnt1", CNT, 32'h0, 32'h1, 1'b0, res, lat);
        check("midrst count f1", res, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
